// File: rtl/gates_pkg.sv
// Shared types and constants for the gates block and its BIST sequencer.
package gates_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    CHECK,
    DONE
  } bist_state_t;

  localparam int NAND = 3;
  localparam int XOR  = 2;
  localparam int OR   = 1;
  localparam int AND  = 0;

  // Expected {nand,xor,or,and}, indexed by {a,b}
  localparam logic [3:0] GOLDEN_Y [4] = '{
    4'b1000,
    4'b1110,
    4'b1110,
    4'b0011
  };

endpackage

// File: rtl/settle_timer.sv
// Loadable down-counter that parks at zero; sets the per-vector settle time.
module settle_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         zero
);

  logic [W-1:0] count;

  assign zero = (count == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (!zero) begin
      count <= count - W'(1);
    end
  end

endmodule

// File: rtl/gates_bist.sv
// BIST sequencer: walks {a,b} through all four vectors and checks y
// against the golden table, keeping first-failure diagnostics.
module gates_bist
  import gates_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       a,
  output logic       b,
  input  logic [3:0] y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [1:0] fail_vec,
  output logic [3:0] fail_y
);

  localparam int TW =
    (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("SETTLE_CYCLES must be at least 1");
  end

  bist_state_t state;
  logic [1:0]  v;
  logic        load;
  logic        tzero;
  logic        miss;
  logic [2:0]  err_next;

  // Reload on every entry to SETTLE
  assign load = (state == IDLE && start) ||
                (state == CHECK && v != 2'd3);

  // Case-equality so X/Z on y is a miss
  assign miss     = (y !== GOLDEN_Y[v]);
  assign err_next = err_count + {2'b00, miss};

  settle_timer #(
    .W(TW)
  ) u_timer (
    .clk  (clk),
    .reset(reset),
    .load (load),
    .value(TW'(SETTLE_CYCLES - 1)),
    .zero (tzero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      v         <= 2'd0;
      a         <= 1'b0;
      b         <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= 3'd0;
      fail_vec  <= 2'd0;
      fail_y    <= 4'd0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            v         <= 2'd0;
            a         <= 1'b0;
            b         <= 1'b0;
            busy      <= 1'b1;
            pass      <= 1'b0;
            err_count <= 3'd0;
            fail_vec  <= 2'd0;
            fail_y    <= 4'd0;
            state     <= SETTLE;
          end
        end
        SETTLE: begin
          if (tzero) state <= CHECK;
        end
        CHECK: begin
          err_count <= err_next;
          if (miss && err_count == 3'd0) begin
            fail_vec <= v;
            fail_y   <= y;
          end
          if (v == 2'd3) begin
            done  <= 1'b1;
            pass  <= (err_next == 3'd0);
            state <= DONE;
          end else begin
            v      <= v + 2'd1;
            {a, b} <= v + 2'd1;
            state  <= SETTLE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          a     <= 1'b0;
          b     <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
